// File: rtl/uart_alu_bridge.sv
// Frame controller between the UART FIFOs and a combinational ALU: pops A, B, OP
// from the RX FIFO, waits one cycle for the ALU result, then pushes it to the TX FIFO.
module uart_alu_bridge #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_empty,
   input  logic [NB_DATA-1:0] i_rx_data,
   output logic               o_rd_uart,
   input  logic               i_tx_full,
   output logic               o_wr_uart,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic               o_busy,
   output logic [7:0]         o_frame_count
);

   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

   state_t             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d;
   logic [NB_DATA-1:0] b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] result_q, result_d;
   logic [7:0]         count_q, count_d;

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can infer a latch.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      result_d  = result_q;
      count_d   = count_q;
      o_rd_uart = 1'b0;
      o_wr_uart = 1'b0;

      // Strobes are gated by reset so the FIFOs see no pop or push during a reset cycle.
      case (state_q)
         GET_A: begin
            o_rd_uart = i_reset && !i_rx_empty;
            if (o_rd_uart) begin
               a_d     = i_rx_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            o_rd_uart = i_reset && !i_rx_empty;
            if (o_rd_uart) begin
               b_d     = i_rx_data;
               state_d = GET_OP;
            end
         end
         GET_OP: begin
            o_rd_uart = i_reset && !i_rx_empty;
            if (o_rd_uart) begin
               op_d    = i_rx_data[NB_OP-1:0];
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = i_alu_result;
            state_d  = SEND;
         end
         SEND: begin
            o_wr_uart = i_reset && !i_tx_full;
            if (o_wr_uart) begin
               count_d = count_q + 8'd1;
               state_d = GET_A;
            end
         end
         default: state_d = GET_A;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!i_reset) begin
         state_q  <= GET_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         count_q  <= count_d;
      end
   end

   assign o_alu_a       = a_q;
   assign o_alu_b       = b_q;
   assign o_alu_op      = op_q;
   assign o_tx_data     = result_q;
   assign o_frame_count = count_q;
   assign o_busy        = (state_q != GET_A);

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Scoreboard bench for uart_alu_bridge: FIFO models and a bench ALU drive the DUT,
// a frame-level model predicts each pushed byte and when it must appear.
module tb_uart_alu_bridge;

   typedef struct {
      logic [7:0] result;
      int         ready;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_rx_empty = 1'b1;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_tx_full = 1'b0;
   logic [7:0] i_alu_result;
   logic       o_rd_uart, o_wr_uart, o_busy;
   logic [7:0] o_tx_data, o_alu_a, o_alu_b, o_frame_count;
   logic [5:0] o_alu_op;

   logic       rst_cmd = 1'b0;
   logic       tx_full_cmd = 1'b0;
   logic [7:0] rx_q[$];
   exp_t       exp_q[$];
   int         pop_log[$];
   int         cycle = 0;
   int         pops_total = 0;
   int         vectors = 0;
   int         miscompares = 0;

   uart_alu_bridge #(.NB_DATA(8), .NB_OP(6)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx_empty   (i_rx_empty),
      .i_rx_data    (i_rx_data),
      .o_rd_uart    (o_rd_uart),
      .i_tx_full    (i_tx_full),
      .o_wr_uart    (o_wr_uart),
      .o_tx_data    (o_tx_data),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_alu_op     (o_alu_op),
      .i_alu_result (i_alu_result),
      .o_busy       (o_busy),
      .o_frame_count(o_frame_count)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b[2:0];
         default: return 8'h00;
      endcase
   endfunction

   always_comb i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // FIFO models: inputs change on the falling edge, the DUT acts on the next rising edge.
   initial begin
      logic [7:0] frame[3];
      int         nfr;
      nfr = 0;
      forever begin
         @(negedge i_clk);
         i_reset    = rst_cmd;
         i_tx_full  = tx_full_cmd;
         i_rx_empty = (rx_q.size() == 0);
         i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
         #1;
         cycle++;
         if (!i_reset) begin
            nfr = 0;
            exp_q.delete();
         end else if (o_rd_uart && !i_rx_empty) begin
            frame[nfr] = rx_q.pop_front();
            nfr++;
            pops_total++;
            pop_log.push_back(cycle);
            if (nfr == 3) begin
               exp_q.push_back('{result: alu_ref(frame[0], frame[1], frame[2][5:0]),
                                 ready: cycle + 2});
               nfr = 0;
            end
         end
      end
   end

   // Monitor: a push must happen exactly on the first non-full cycle at or after ready.
   initial begin
      int   model_count;
      logic post_check;
      logic due;
      exp_t e;
      model_count = 0;
      post_check  = 1'b0;
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_reset) begin
            check("rst_rd", o_rd_uart, 0);
            check("rst_wr", o_wr_uart, 0);
            model_count = 0;
            post_check  = 1'b1;
         end else begin
            check("rd_while_empty", o_rd_uart & i_rx_empty, 0);
            check("rd_wr_same_cycle", o_rd_uart & o_wr_uart, 0);
            if (post_check) begin
               check("frame_count", o_frame_count, model_count[7:0]);
               check("busy_idle", o_busy, 0);
               post_check = 1'b0;
            end
            if (o_rd_uart)
               check("pop_outside_get", exp_q.size() > 0 && exp_q[0].ready != cycle + 2, 0);
            due = exp_q.size() > 0 && cycle >= exp_q[0].ready && !i_tx_full;
            check("push_timing", o_wr_uart, due);
            if (due) begin
               e = exp_q.pop_front();
               check("tx_data", o_tx_data, e.result);
               model_count++;
               post_check = 1'b1;
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge i_clk);
      rst_cmd = 1'b0;
      @(posedge i_clk);
      rst_cmd = 1'b1;
   endtask

   task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      rx_q.push_back(a);
      rx_q.push_back(b);
      rx_q.push_back(op);
   endtask

   task automatic wait_pops(input int target, input int budget);
      int n;
      n = 0;
      while (pops_total < target && n < budget) begin
         @(posedge i_clk);
         n++;
      end
      check("wait_pops", pops_total >= target, 1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((rx_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(posedge i_clk);
         n++;
      end
      check("wait_idle", rx_q.size() + exp_q.size(), 0);
      repeat (2) @(posedge i_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops[7];
      int         base;
      ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02};

      repeat (3) @(posedge i_clk);
      rst_cmd = 1'b1;
      @(negedge i_clk);
      #3;
      check("reset_busy", o_busy, 0);
      check("reset_count", o_frame_count, 0);
      check("reset_tx_data", o_tx_data, 0);

      // Basic add frame.
      @(posedge i_clk);
      push_frame(8'h05, 8'h03, 8'h20);
      wait_idle(50);
      check("add_count", o_frame_count, 1);
      check("add_tx_data", o_tx_data, 8'h08);

      // Same frame with 50 empty cycles between bytes.
      for (int i = 0; i < 3; i++) begin
         base = pops_total;
         rx_q.push_back(i == 0 ? 8'h05 : (i == 1 ? 8'h03 : 8'h20));
         wait_pops(base + 1, 20);
         repeat (50) @(posedge i_clk);
      end
      wait_idle(50);
      check("gap_count", o_frame_count, 2);

      // Two preloaded frames: pop spacing 1,1 then 3 (EXEC, SEND, pop) then 1,1.
      do_reset();
      pop_log.delete();
      push_frame(8'h10, 8'h22, 8'h20);
      push_frame(8'hF0, 8'h0F, 8'h25);
      wait_idle(100);
      check("two_pop_count", pop_log.size(), 6);
      if (pop_log.size() == 6) begin
         check("two_gap0", pop_log[1] - pop_log[0], 1);
         check("two_gap1", pop_log[2] - pop_log[1], 1);
         check("two_gap2", pop_log[3] - pop_log[2], 3);
         check("two_gap3", pop_log[4] - pop_log[3], 1);
         check("two_gap4", pop_log[5] - pop_log[4], 1);
      end
      check("two_count", o_frame_count, 2);

      // TX backpressure for 20 cycles in SEND; queued RX bytes must wait.
      tx_full_cmd = 1'b1;
      base = pops_total;
      push_frame(8'h09, 8'h04, 8'h22);
      wait_pops(base + 3, 20);
      push_frame(8'h07, 8'h02, 8'h24);
      @(posedge i_clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         #3;
         check("bp_tx_data", o_tx_data, 8'h05);
         check("bp_busy", o_busy, 1);
      end
      check("bp_no_pops", pops_total, base + 3);
      @(posedge i_clk);
      tx_full_cmd = 1'b0;
      wait_idle(100);
      check("bp_count", o_frame_count, 4);

      // Reset after A and B are popped discards the partial frame.
      base = pops_total;
      rx_q.push_back(8'h33);
      rx_q.push_back(8'h44);
      wait_pops(base + 2, 20);
      do_reset();
      @(negedge i_clk);
      #3;
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_a", o_alu_a, 0);
      check("mid_rst_b", o_alu_b, 0);
      check("mid_rst_op", o_alu_op, 0);
      check("mid_rst_count", o_frame_count, 0);
      @(posedge i_clk);
      push_frame(8'h01, 8'h01, 8'h20);
      wait_idle(50);
      check("mid_rst_result", o_tx_data, 8'h02);

      // Randomized frames, gaps and TX backpressure; opcode byte has random upper bits.
      for (int f = 0; f < 40; f++) begin
         push_frame(8'($urandom), 8'($urandom),
                    {2'($urandom), ops[$urandom_range(0, 6)]});
         repeat ($urandom_range(0, 8)) begin
            @(posedge i_clk);
            tx_full_cmd = ($urandom_range(0, 3) == 0);
         end
      end
      @(posedge i_clk);
      tx_full_cmd = 1'b0;
      wait_idle(2000);

      // 256 back-to-back frames wrap the count to zero.
      do_reset();
      for (int f = 0; f < 256; f++)
         push_frame(8'(f), 8'h01, 8'h20);
      wait_idle(3000);
      check("wrap_count", o_frame_count, 0);
      check("wrap_last", o_tx_data, 8'h00);

      repeat (3) @(posedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_alu_bridge.md
# uart_alu_bridge

Frame-level controller on the user side of the UART interface. It drains operand and opcode bytes from the RX FIFO, presents them to the combinational ALU, and pushes the one-byte result into the TX FIFO. It is the consumer/producer at the far end of the FIFO read/write handshake that the UART interface exposes.

## Interface

Parameters:
- NB_DATA, 8, width of UART bytes, operands and result
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-low reset
- i_rx_empty  input  1  RX FIFO empty flag
- i_rx_data  input  NB_DATA  RX FIFO head byte; valid whenever i_rx_empty=0
- o_rd_uart  output  1  RX FIFO pop strobe
- i_tx_full  input  1  TX FIFO full flag
- o_wr_uart  output  1  TX FIFO push strobe
- o_tx_data  output  NB_DATA  byte pushed into the TX FIFO
- o_alu_a  output  NB_DATA  registered operand A to the ALU
- o_alu_b  output  NB_DATA  registered operand B to the ALU
- o_alu_op  output  NB_OP  registered opcode to the ALU
- i_alu_result  input  NB_DATA  combinational ALU result
- o_busy  output  1  high when the state is not GET_A
- o_frame_count  output  8  number of results written; wraps from 0xFF to 0x00

## Operation

- Frame format is fixed at three bytes in order: A, B, OP. One result byte is returned per frame.
- FSM states are GET_A, GET_B, GET_OP, EXEC and SEND. The reset state is GET_A.
- GET_A, GET_B and GET_OP:
  - o_rd_uart = !i_rx_empty (combinational).
  - On a clock edge with o_rd_uart=1, the state captures i_rx_data into the A, B or OP register (OP takes i_rx_data[NB_OP-1:0]) and advances.
  - When i_rx_empty=1 the state holds with no pop.
- EXEC lasts exactly one cycle. o_alu_a, o_alu_b and o_alu_op already hold the captured values. At the edge, i_alu_result is latched into the result register and the state goes to SEND.
- SEND:
  - o_wr_uart = !i_tx_full (combinational).
  - On an edge with o_wr_uart=1: state goes to GET_A and o_frame_count increments modulo 256.
  - When i_tx_full=1 the state holds.
- o_tx_data always equals the result register.
- o_rd_uart is never high while i_rx_empty=1. o_wr_uart is never high while i_tx_full=1.
- o_rd_uart and o_wr_uart are never high in the same cycle.
- No pops occur outside the GET states, so RX bytes wait in the FIFO during EXEC and SEND.
- No arithmetic is done in this block. The count is unsigned 8-bit and wraps.

## Timing

- Reset (i_reset=0 at an edge):
  - state becomes GET_A.
  - A, B, OP, result and o_frame_count clear to 0.
  - o_rd_uart and o_wr_uart are 0 for the whole cycle in which i_reset=0.
  - o_busy is 0 after reset.
- Reset mid-frame discards the partial frame. Bytes already popped are lost, and the next three bytes form a new frame.
- Pop timing: a byte is consumed in the same cycle it is seen non-empty. Back-to-back pops on consecutive cycles are allowed when the FIFO stays non-empty.
- Minimum frame latency, taking cycle 0 as the OP pop cycle:
  - cycle 1 is EXEC;
  - cycle 2 is SEND with o_wr_uart=1 when TX is not full.
  - So a fully preloaded frame costs 5 cycles from the first pop to the push, inclusive.
- The ALU result must settle within one cycle of o_alu_* becoming stable. Because the operands are registered, this is guaranteed by construction.
- TX backpressure: o_tx_data stays stable and the block stays in SEND indefinitely. It resumes on the first cycle with i_tx_full=0.
- If i_tx_full falls in the same cycle that a new RX byte arrives, the push happens first. The pop occurs no earlier than the next cycle, in GET_A.

## Test plan

- Frame with A=0x05, B=0x03, OP=0x20 and the bench ALU computing A+B -> o_wr_uart pulses once with o_tx_data=0x08, then o_frame_count=1 and o_busy=0.
- Same frame with i_rx_empty high for 50 cycles between bytes -> no o_rd_uart pulse while empty; result 0x08 is pushed exactly 2 cycles after the OP pop.
- i_tx_full held high for 20 cycles while in SEND on A=0x09, B=0x04, OP=0x22 (A-B) -> o_wr_uart stays 0, o_tx_data stays at 0x05, no RX pops; exactly one push occurs on the first non-full cycle.
- Two frames preloaded in the RX FIFO (six bytes) -> pops on consecutive cycles within each frame, two pushes in order, o_frame_count=2.
- i_reset driven low for 1 cycle after A and B are popped -> state is GET_A and outputs are 0; the next three bytes 0x01, 0x01, 0x20 yield a result of 0x02.
- 256 back-to-back frames -> o_frame_count wraps to 0x00 after the 256th push.
